scr1_accel_vmul: RTL and testbench
==================================

Name: scr1_accel_vmul

Overview:
- Memory-mapped lane-wise vector multiply accelerator on the SCR1 core data-memory interface.
- Holds DEPTH-word operand buffers A and B and a result buffer C. On a GO write it processes LEN words one lane per cycle, in one of three modes: MUL, MAC or DOT.
- Software polls STATUS for completion, then reads C or SCALAR.

Parameters:
- LANE_W, 8, lane width in bits; legal values 8, 16, 32. LANES = 32/LANE_W.
- DEPTH, 8, words per buffer; legal range 1..64.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- dmem_req  in  1  request strobe
- dmem_cmd  in  type_scr1_mem_cmd_e  RD/WR
- dmem_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD
- dmem_addr  in  SCR1_DMEM_AWIDTH  byte address
- dmem_wdata  in  SCR1_DMEM_DWIDTH  write data
- dmem_req_ack  out  1  request accepted
- dmem_rdata  out  SCR1_DMEM_DWIDTH  read data
- dmem_resp  out  type_scr1_mem_resp_e  response
- irq  out  1  completion interrupt (present only with the optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all registers, all three buffers and dmem_rdata reset to 0; dmem_resp resets to NOTRDY.
- Handshake: dmem_req_ack is constant 1. dmem_resp = RDY_OK in the cycle after every accepted request, otherwise NOTRDY. Back-to-back requests are each answered one cycle later.
- Read data: registered, valid in the RDY_OK cycle, right-shifted by 8*addr[1:0] captured with the request.
- Decode: word index = dmem_addr[9:2].
  - 0 CTRL/STATUS. Write: bit0 GO; bits[2:1] MODE (0 MUL, 1 MAC, 2 DOT, 3 reserved = MUL); bit3 IRQ_EN; bit31 write-1-clears DONE. Read: {DONE, 27'b0, IRQ_EN, MODE, BUSY}.
  - 1 COUNT: read-only, 16-bit RUN-cycle count, zero-extended.
  - 2 LEN: bits[6:0] R/W.
  - 3 SCALAR: R/W, 32 bits.
  - 16+i: A[i]. 16+DEPTH+i: B[i]. 16+2*DEPTH+i: C[i], R/W.
  - Unmapped addresses read 0; writes to them are ignored.
- Sub-word writes: write only the addressed byte or halfword lane (byte enables from dmem_addr[1:0] and dmem_width). Other bytes are preserved.
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE, on a GO write -> RUN next cycle. On entry: COUNT=0, DONE=0, word idx=0, lane=0. MODE and IRQ_EN are latched from the same write. DOT mode does not clear SCALAR; software clears it.
  - RUN, each cycle, on lane l of word w: P = A[w].lane(l) * B[w].lane(l), 2*LANE_W bits unsigned.
    - MUL: C[w].lane(l) = P[LANE_W-1:0].
    - MAC: C[w].lane(l) = C[w].lane(l) + P[LANE_W-1:0], modulo 2^LANE_W.
    - DOT: SCALAR = SCALAR + zero-extended P, modulo 2^32. For LANE_W=32, P is truncated to 32 bits.
  - RUN, COUNT increments each cycle and saturates at 0xFFFF. Lane advances each cycle; word advances after lane LANES-1.
  - RUN, after the last lane of word L-1 -> DONE, where L = min(LEN, DEPTH). Latency = L*LANES cycles; BUSY is high exactly those cycles.
  - LEN=0: one RUN cycle with no data update, then DONE, COUNT=1.
  - DONE: DONE=1 and stays set until the next GO or a W1C write.
- While BUSY:
  - GO, MODE and LEN writes are ignored; an IRQ_EN write is accepted.
  - Buffer and SCALAR writes are ignored.
  - Buffer reads return the current value.
- Same-cycle W1C and DONE set: set wins.
- Reset mid-RUN: immediate return to IDLE with every register at its reset value.

Optional Feature:
- Macro: SCR1_ACCEL_VMUL_IRQ_EN.
- Defined: irq port exists; irq = registered (DONE & IRQ_EN). It asserts the cycle after DONE sets and deasserts the cycle after W1C, GO or IRQ_EN=0.
- Undefined: no irq port. IRQ_EN stays R/W but has no effect.

Test Plan:
- MUL, LANE_W=8: A0=0x04030201, B0=0x05050505, LEN=1, GO -> BUSY for 4 cycles, DONE=1, C0=0x140F0A05, COUNT=4.
- MAC: repeat the previous GO with MODE=1 -> C0=0x281E140A. Lane overflow: A0=B0=0x000000FF, MUL -> C0=0x00000001.
- DOT: SCALAR=0, A0=0x04030201, B0=0x05050505, LEN=1 -> SCALAR=0x32. Then A0=B0=0xFFFFFFFF -> SCALAR=0x32+4*0xFE01=0x3F836.
- Clamp and empty: LEN=100 with DEPTH=8 -> COUNT=32, DONE. LEN=0 -> COUNT=1, C unchanged.
- Protection: GO and an A0 write during RUN -> ignored, result unchanged. Byte write 0xAA to A0 byte 1 -> A0=0x0403AA01.
- Reset and handshake: assert rst_n=0 at cycle 2 of RUN -> all registers 0, IDLE. Back-to-back reads -> RDY_OK on each following cycle with correct shifted data. With the macro defined: irq rises one cycle after DONE and falls after W1C.

Source files
------------

// File: rtl/scr1_accel_vmul.sv
// Lane-wise vector multiply accelerator (MUL / MAC / DOT) on the SCR1 data-memory bus.
// Optional completion interrupt port enabled by defining SCR1_ACCEL_VMUL_IRQ_EN.

package scr1_accel_vmul_pkg;
    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_accel_vmul
    import scr1_accel_vmul_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int DEPTH  = 8
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        dmem_req,
    input  type_scr1_mem_cmd_e          dmem_cmd,
    input  type_scr1_mem_width_e        dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    output logic                        dmem_req_ack,
    output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    output type_scr1_mem_resp_e         dmem_resp
`ifdef SCR1_ACCEL_VMUL_IRQ_EN
    ,
    output logic                        irq
`endif
);

    localparam int LANES = 32 / LANE_W;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] MODE_MAC = 2'd1;
    localparam logic [1:0] MODE_DOT = 2'd2;

    localparam logic [8:0] IDX_CTRL   = 9'd0;
    localparam logic [8:0] IDX_COUNT  = 9'd1;
    localparam logic [8:0] IDX_LEN    = 9'd2;
    localparam logic [8:0] IDX_SCALAR = 9'd3;
    localparam logic [8:0] BASE_A     = 9'd16;
    localparam logic [8:0] BASE_B     = 9'(16 + DEPTH);
    localparam logic [8:0] BASE_C     = 9'(16 + 2 * DEPTH);
    localparam logic [8:0] BASE_END   = 9'(16 + 3 * DEPTH);

    localparam logic [6:0]    DEPTH_L   = 7'(DEPTH);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    logic [1:0]    r_state;
    logic [1:0]    r_mode;
    logic          r_irq_en;
    logic          r_done;
    logic [15:0]   r_count;
    logic [6:0]    r_len;
    logic [31:0]   r_scalar;
    logic [IW-1:0] r_word;
    logic [LW-1:0] r_lane;
    logic [31:0]   r_buf_a [DEPTH];
    logic [31:0]   r_buf_b [DEPTH];
    logic [31:0]   r_buf_c [DEPTH];
    logic          r_resp_ok;
    logic [31:0]   r_rdata;

    logic          w_busy;
    logic          w_wr;
    logic          w_rd;
    logic          w_go;
    logic [8:0]    w_widx;
    logic          w_hit_a;
    logic          w_hit_b;
    logic          w_hit_c;
    logic [8:0]    w_off_a;
    logic [8:0]    w_off_b;
    logic [8:0]    w_off_c;
    logic [IW-1:0] w_ia;
    logic [IW-1:0] w_ib;
    logic [IW-1:0] w_ic;
    logic [3:0]    w_be;
    logic [31:0]   w_bmask;
    logic [31:0]   w_wdata_r;
    logic [31:0]   w_rword;
    logic          w_unused_addr;

    logic [31:0]           w_a_word;
    logic [31:0]           w_b_word;
    logic [31:0]           w_c_word;
    logic [LANE_W-1:0]     w_a_lane;
    logic [LANE_W-1:0]     w_b_lane;
    logic [LANE_W-1:0]     w_c_lane;
    logic [2*LANE_W-1:0]   w_prod;
    logic [LANE_W-1:0]     w_c_lane_new;
    logic [31:0]           w_c_word_new;
    logic [31:0]           w_dot_add;
    logic [6:0]            w_eff_len;
    logic                  w_empty;
    logic                  w_last;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign dmem_req_ack  = 1'b1;
    assign dmem_resp     = r_resp_ok ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
    assign dmem_rdata    = r_rdata;
    assign w_unused_addr = ^dmem_addr[31:10];

    assign w_busy = (r_state == ST_RUN);
    assign w_wr   = dmem_req && (dmem_cmd == SCR1_MEM_CMD_WR);
    assign w_rd   = dmem_req && (dmem_cmd == SCR1_MEM_CMD_RD);

    // Bus address decode
    assign w_widx  = {1'b0, dmem_addr[9:2]};
    assign w_hit_a = (w_widx >= BASE_A) && (w_widx < BASE_B);
    assign w_hit_b = (w_widx >= BASE_B) && (w_widx < BASE_C);
    assign w_hit_c = (w_widx >= BASE_C) && (w_widx < BASE_END);
    assign w_off_a = w_widx - BASE_A;
    assign w_off_b = w_widx - BASE_B;
    assign w_off_c = w_widx - BASE_C;
    assign w_ia    = w_off_a[IW-1:0];
    assign w_ib    = w_off_b[IW-1:0];
    assign w_ic    = w_off_c[IW-1:0];

    // Sub-word data arrives in the low bits; replicate it so every lane sees it
    always_comb begin
        w_be      = 4'b1111;
        w_wdata_r = dmem_wdata;
        case (dmem_width)
            SCR1_MEM_WIDTH_BYTE: begin
                w_be      = 4'b0001 << dmem_addr[1:0];
                w_wdata_r = {4{dmem_wdata[7:0]}};
            end
            SCR1_MEM_WIDTH_HWORD: begin
                w_be      = dmem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_r = {2{dmem_wdata[15:0]}};
            end
            default: begin
                w_be      = 4'b1111;
                w_wdata_r = dmem_wdata;
            end
        endcase
    end

    assign w_bmask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_go    = w_wr && (w_widx == IDX_CTRL) && w_be[0] && w_wdata_r[0] && !w_busy;

    always_comb begin
        w_rword = '0;
        if (w_widx == IDX_CTRL)
            w_rword = {r_done, 27'b0, r_irq_en, r_mode, w_busy};
        else if (w_widx == IDX_COUNT)
            w_rword = {16'b0, r_count};
        else if (w_widx == IDX_LEN)
            w_rword = {25'b0, r_len};
        else if (w_widx == IDX_SCALAR)
            w_rword = r_scalar;
        else if (w_hit_a)
            w_rword = r_buf_a[w_ia];
        else if (w_hit_b)
            w_rword = r_buf_b[w_ib];
        else if (w_hit_c)
            w_rword = r_buf_c[w_ic];
    end

    assign w_a_word = r_buf_a[r_word];
    assign w_b_word = r_buf_b[r_word];
    assign w_c_word = r_buf_c[r_word];
    assign w_a_lane = w_a_word[r_lane*LANE_W +: LANE_W];
    assign w_b_lane = w_b_word[r_lane*LANE_W +: LANE_W];
    assign w_c_lane = w_c_word[r_lane*LANE_W +: LANE_W];
    assign w_prod   = (2*LANE_W)'(w_a_lane) * (2*LANE_W)'(w_b_lane);

    assign w_c_lane_new = (r_mode == MODE_MAC) ? (w_c_lane + w_prod[LANE_W-1:0])
                                               : w_prod[LANE_W-1:0];

    always_comb begin
        w_c_word_new = w_c_word;
        w_c_word_new[r_lane*LANE_W +: LANE_W] = w_c_lane_new;
    end

    generate
        if (2 * LANE_W >= 32) begin : g_dot_trunc
            assign w_dot_add = w_prod[31:0];
        end else begin : g_dot_ext
            assign w_dot_add = 32'(w_prod);
        end
    endgenerate

    assign w_eff_len = (r_len > DEPTH_L) ? DEPTH_L : r_len;
    assign w_empty   = (w_eff_len == 7'd0);
    assign w_last    = w_empty ||
                       ((r_lane == LAST_LANE) && (7'(r_word) == (w_eff_len - 7'd1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mode    <= '0;
            r_irq_en  <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_len     <= '0;
            r_scalar  <= '0;
            r_word    <= '0;
            r_lane    <= '0;
            r_resp_ok <= 1'b0;
            r_rdata   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_buf_a[i] <= '0;
                r_buf_b[i] <= '0;
                r_buf_c[i] <= '0;
            end
        end else begin
            r_resp_ok <= dmem_req;
            if (w_rd)
                r_rdata <= w_rword >> {dmem_addr[1:0], 3'b000};

            if (w_wr && (w_widx == IDX_CTRL)) begin
                if (w_be[0])
                    r_irq_en <= w_wdata_r[3];
                if (w_be[0] && !w_busy)
                    r_mode <= w_wdata_r[2:1];
                if (w_be[3] && w_wdata_r[31])
                    r_done <= 1'b0;
            end

            if (w_wr && !w_busy) begin
                if ((w_widx == IDX_LEN) && w_be[0])
                    r_len <= w_wdata_r[6:0];
                if (w_widx == IDX_SCALAR)
                    r_scalar <= f_merge(r_scalar, w_wdata_r, w_bmask);
                if (w_hit_a)
                    r_buf_a[w_ia] <= f_merge(r_buf_a[w_ia], w_wdata_r, w_bmask);
                if (w_hit_b)
                    r_buf_b[w_ib] <= f_merge(r_buf_b[w_ib], w_wdata_r, w_bmask);
                if (w_hit_c)
                    r_buf_c[w_ic] <= f_merge(r_buf_c[w_ic], w_wdata_r, w_bmask);
            end

            // FSM follows the bus writes so a DONE set overrides a same-cycle W1C
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_go) begin
                        r_state <= ST_RUN;
                        r_count <= '0;
                        r_done  <= 1'b0;
                        r_word  <= '0;
                        r_lane  <= '0;
                    end
                end
                ST_RUN: begin
                    if (r_count != 16'hFFFF)
                        r_count <= r_count + 16'd1;
                    if (!w_empty) begin
                        if (r_mode == MODE_DOT)
                            r_scalar <= r_scalar + w_dot_add;
                        else
                            r_buf_c[r_word] <= w_c_word_new;
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (r_lane == LAST_LANE) begin
                        r_lane <= '0;
                        r_word <= r_word + 1'b1;
                    end else begin
                        r_lane <= r_lane + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SCR1_ACCEL_VMUL_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_irq <= 1'b0;
        else
            r_irq <= r_done & r_irq_en;
    end

    assign irq = r_irq;
`endif

endmodule

// File: tb/tb_scr1_accel_vmul.sv
// Self-checking bench for scr1_accel_vmul: vector table plus hand sequences, bus reads scored via a queue.
module tb_scr1_accel_vmul;
    import scr1_accel_vmul_pkg::*;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_COUNT  = 32'h04;
    localparam logic [31:0] A_LEN    = 32'h08;
    localparam logic [31:0] A_SCALAR = 32'h0C;
    localparam logic [31:0] A_A0     = 32'h40;
    localparam logic [31:0] A_B0     = 32'h60;
    localparam logic [31:0] A_C0     = 32'h80;
    localparam logic [31:0] A_A7     = 32'h5C;
    localparam logic [31:0] A_B7     = 32'h7C;
    localparam logic [31:0] A_C7     = 32'h9C;
    localparam logic [31:0] A_UNMAP  = 32'h3FC;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 dmem_req;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [31:0]          dmem_addr;
    logic [31:0]          dmem_wdata;
    logic                 dmem_req_ack;
    logic [31:0]          dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;
`ifdef SCR1_ACCEL_VMUL_IRQ_EN
    logic                 irq;
`endif

    scr1_accel_vmul #(.LANE_W(8), .DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_req_ack (dmem_req_ack),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp)
`ifdef SCR1_ACCEL_VMUL_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] c0_init;
        logic [31:0] sc_init;
        logic [31:0] len;
        logic [31:0] exp_c0;
        logic [31:0] exp_sc;
        logic [31:0] exp_cnt;
    } vec_t;

    sb_t         sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_rdata;
    logic        exp_resp;
    vec_t        vt[7];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_resp <= 1'b0;
        else        exp_resp <= dmem_req;
    end

    always @(negedge clk) begin : mon
        sb_t e;
        if (exp_resp) begin
            n_tests++;
            if (dmem_resp != SCR1_MEM_RESP_RDY_OK) begin
                n_fail++;
                $display("FAIL resp_ok: dmem_resp=%0d, required %0d", dmem_resp, SCR1_MEM_RESP_RDY_OK);
            end
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: response with no request outstanding");
            end else begin
                e = sb.pop_front();
                if (e.is_rd) begin
                    last_rdata = dmem_rdata;
                    if (e.chk) begin
                        n_tests++;
                        if (dmem_rdata !== e.exp) begin
                            n_fail++;
                            $display("FAIL %s: got %h, required %h", e.name, dmem_rdata, e.exp);
                        end
                    end
                end
            end
        end else if (rst_n && dmem_resp != SCR1_MEM_RESP_NOTRDY) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_stray: dmem_resp=%0d, required NOTRDY", dmem_resp);
        end
    end

    task automatic op(input logic wr, input type_scr1_mem_width_e w, input logic [31:0] addr,
                      input logic [31:0] wd, input logic chk, input logic [31:0] exp, input string name);
        sb_t e;
        dmem_req   = 1'b1;
        dmem_cmd   = wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        dmem_width = w;
        dmem_addr  = addr;
        dmem_wdata = wd;
        e.is_rd = !wr;
        e.chk   = chk;
        e.exp   = exp;
        e.name  = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        dmem_req = 1'b0;
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] d);
        op(1'b1, SCR1_MEM_WIDTH_WORD, addr, d, 1'b0, '0, "wr");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        op(1'b0, SCR1_MEM_WIDTH_WORD, addr, '0, 1'b1, exp, name);
    endtask

    task automatic rd_nc(input logic [31:0] addr);
        op(1'b0, SCR1_MEM_WIDTH_WORD, addr, '0, 1'b0, '0, "poll");
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            rd_nc(A_CTRL);
            if (last_rdata[31]) ok = 1'b1;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: status %h after 100 polls, required DONE=1", name, last_rdata);
        end
    endtask

    task automatic chk_direct(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // mode, a0, b0, c0_init, sc_init, len, exp_c0, exp_sc, exp_cnt
        vt[0] = '{2'd0, 32'h04030201, 32'h05050505, 32'h0,        32'h0,     32'd1, 32'h140F0A05, 32'h0,       32'd4};
        vt[1] = '{2'd1, 32'h04030201, 32'h05050505, 32'h140F0A05, 32'h0,     32'd1, 32'h281E140A, 32'h0,       32'd4};
        vt[2] = '{2'd0, 32'h000000FF, 32'h000000FF, 32'hDEADBEEF, 32'h0,     32'd1, 32'h00000001, 32'h0,       32'd4};
        vt[3] = '{2'd2, 32'h04030201, 32'h05050505, 32'h00000055, 32'h0,     32'd1, 32'h00000055, 32'h32,      32'd4};
        vt[4] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000055, 32'h32,    32'd1, 32'h00000055, 32'h0003F836, 32'd4};
        vt[5] = '{2'd1, 32'h11223344, 32'h03030303, 32'hF0F0F0F0, 32'h0,     32'd1, 32'h235689BC, 32'h0,       32'd4};
        vt[6] = '{2'd3, 32'h04030201, 32'h05050505, 32'h11111111, 32'h1234,  32'd1, 32'h140F0A05, 32'h1234,    32'd4};

        rst_n      = 1'b0;
        dmem_req   = 1'b0;
        dmem_cmd   = SCR1_MEM_CMD_RD;
        dmem_width = SCR1_MEM_WIDTH_WORD;
        dmem_addr  = '0;
        dmem_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_direct("rst_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        chk_direct("rst_rdata", dmem_rdata, 32'h0);
        rst_n = 1'b1;

        rd(A_CTRL,   32'h0, "rst_ctrl");
        rd(A_COUNT,  32'h0, "rst_count");
        rd(A_LEN,    32'h0, "rst_len");
        rd(A_SCALAR, 32'h0, "rst_scalar");
        rd(A_A0,     32'h0, "rst_a0");
        rd(A_C7,     32'h0, "rst_c7");
        wr32(A_UNMAP, 32'hFFFFFFFF);
        rd(A_UNMAP,  32'h0, "unmapped");

        for (int i = 0; i < 7; i++) begin
            wr32(A_A0, vt[i].a0);
            wr32(A_B0, vt[i].b0);
            wr32(A_C0, vt[i].c0_init);
            wr32(A_SCALAR, vt[i].sc_init);
            wr32(A_LEN, vt[i].len);
            wr32(A_CTRL, {29'b0, vt[i].mode, 1'b1});
            wait_done($sformatf("v%0d_done", i));
            rd(A_C0, vt[i].exp_c0, $sformatf("v%0d_c0", i));
            rd(A_SCALAR, vt[i].exp_sc, $sformatf("v%0d_scalar", i));
            rd(A_COUNT, vt[i].exp_cnt, $sformatf("v%0d_count", i));
            rd(A_CTRL, {1'b1, 27'b0, 1'b0, vt[i].mode, 1'b0}, $sformatf("v%0d_status", i));
            wr32(A_CTRL, 32'h80000000);
        end

        // BUSY exactly LEN*LANES cycles, back-to-back status reads
        wr32(A_LEN, 32'd1);
        wr32(A_CTRL, 32'h1);
        for (int k = 1; k <= 4; k++) rd(A_CTRL, 32'h00000001, $sformatf("busy_c%0d", k));
        rd(A_CTRL, 32'h80000000, "busy_end");
        wr32(A_CTRL, 32'h80000000);
        rd(A_CTRL, 32'h0, "w1c_clear");

        // LEN clamped to DEPTH; last word must be processed
        wr32(A_A7, 32'h01020304);
        wr32(A_B7, 32'h02020202);
        wr32(A_LEN, 32'd100);
        rd(A_LEN, 32'd100, "len_rw");
        wr32(A_CTRL, 32'h1);
        wait_done("clamp_done");
        rd(A_COUNT, 32'd32, "clamp_count");
        rd(A_C7, 32'h02040608, "clamp_c7");
        wr32(A_CTRL, 32'h80000000);

        // LEN=0: single RUN cycle, no data update
        wr32(A_C0, 32'h12345678);
        wr32(A_LEN, 32'd0);
        wr32(A_CTRL, 32'h1);
        rd(A_CTRL, 32'h00000001, "len0_busy");
        rd(A_CTRL, 32'h80000000, "len0_done");
        rd(A_COUNT, 32'd1, "len0_count");
        rd(A_C0, 32'h12345678, "len0_c0");
        wr32(A_CTRL, 32'h80000000);

        // W1C landing on the cycle DONE sets: DONE must remain set
        wr32(A_LEN, 32'd1);
        wr32(A_CTRL, 32'h1);
        for (int k = 1; k <= 3; k++) rd(A_CTRL, 32'h00000001, $sformatf("race_busy%0d", k));
        wr32(A_CTRL, 32'h80000000);
        rd(A_CTRL, 32'h80000000, "race_set_wins");
        wr32(A_CTRL, 32'h80000000);
        rd(A_CTRL, 32'h0, "race_cleared");

        // Writes during RUN: GO/MODE/LEN/buffers/SCALAR ignored, IRQ_EN accepted
        wr32(A_A0, 32'h04030201);
        wr32(A_B0, 32'h05050505);
        wr32(A_C0, 32'h0);
        wr32(A_SCALAR, 32'h77);
        wr32(A_LEN, 32'd1);
        wr32(A_CTRL, 32'h1);
        wr32(A_A0, 32'hFFFFFFFF);
        wr32(A_CTRL, 32'h0000000D);
        wr32(A_LEN, 32'd5);
        wr32(A_SCALAR, 32'h99);
        wait_done("prot_done");
        rd(A_C0, 32'h140F0A05, "prot_c0");
        rd(A_A0, 32'h04030201, "prot_a0");
        rd(A_LEN, 32'd1, "prot_len");
        rd(A_SCALAR, 32'h77, "prot_scalar");
        rd(A_COUNT, 32'd4, "prot_count");
        rd(A_CTRL, 32'h80000008, "prot_status");
        wr32(A_CTRL, 32'h80000000);
        rd(A_CTRL, 32'h0, "prot_cleared");

        // Sub-word writes and shifted back-to-back reads
        op(1'b1, SCR1_MEM_WIDTH_BYTE, A_A0 + 32'd1, 32'h000000AA, 1'b0, '0, "wr");
        rd(A_A0, 32'h0403AA01, "byte_wr");
        op(1'b1, SCR1_MEM_WIDTH_HWORD, A_A0 + 32'd2, 32'h0000BEEF, 1'b0, '0, "wr");
        op(1'b0, SCR1_MEM_WIDTH_WORD,  A_A0,         '0, 1'b1, 32'hBEEFAA01, "rd_off0");
        op(1'b0, SCR1_MEM_WIDTH_BYTE,  A_A0 + 32'd1, '0, 1'b1, 32'h00BEEFAA, "rd_off1");
        op(1'b0, SCR1_MEM_WIDTH_HWORD, A_A0 + 32'd2, '0, 1'b1, 32'h0000BEEF, "rd_off2");
        op(1'b0, SCR1_MEM_WIDTH_BYTE,  A_A0 + 32'd3, '0, 1'b1, 32'h000000BE, "rd_off3");

`ifdef SCR1_ACCEL_VMUL_IRQ_EN
        wr32(A_LEN, 32'd1);
        wr32(A_CTRL, 32'h00000009);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk_direct($sformatf("irq_c%0d", k), {31'b0, irq}, {31'b0, (k >= 5)});
        end
        wr32(A_CTRL, 32'h80000008);
        @(negedge clk);
        chk_direct("irq_hold", {31'b0, irq}, 32'h1);
        @(negedge clk);
        chk_direct("irq_fall", {31'b0, irq}, 32'h0);
`endif

        // Asynchronous reset in the middle of RUN
        wr32(A_SCALAR, 32'h1234);
        wr32(A_LEN, 32'd8);
        wr32(A_CTRL, 32'h1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk_direct("mid_rst_resp", 32'(dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        chk_direct("mid_rst_rdata", dmem_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(A_CTRL,   32'h0, "mrst_ctrl");
        rd(A_COUNT,  32'h0, "mrst_count");
        rd(A_LEN,    32'h0, "mrst_len");
        rd(A_SCALAR, 32'h0, "mrst_scalar");
        rd(A_A0,     32'h0, "mrst_a0");
        rd(A_B0,     32'h0, "mrst_b0");
        rd(A_C0,     32'h0, "mrst_c0");

        repeat (3) @(posedge clk);
        #1;
        chk_direct("sb_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
